// File: rtl/dcache_ctrl_if.sv
// Request/response and memory-bus signal bundle for the direct-mapped data cache.
// "master" is the requester plus bus memory side; "slave" is the cache controller.
interface dcache_ctrl_if;
  logic        dcache_en;
  logic        dcache_wren;
  logic [63:0] dcache_addr;
  logic [63:0] dcache_wdata;
  logic [63:0] dcache_rdata;
  logic        dcache_done;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic        bus_ack;
  logic [63:0] bus_rdata;

  modport master (
    output dcache_en, dcache_wren, dcache_addr, dcache_wdata, bus_ack, bus_rdata,
    input  dcache_rdata, dcache_done, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    input  dcache_en, dcache_wren, dcache_addr, dcache_wdata, bus_ack, bus_rdata,
    output dcache_rdata, dcache_done, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// with one 64-bit word per line and a single outstanding bus transaction.
module dcache_ctrl #(
  parameter int LINES = 64,
  parameter int IDXW  = $clog2(LINES)
) (
  input logic         clk,
  input logic         reset_n,
  dcache_ctrl_if.slave cif
);

  localparam int TAGW = 64 - IDXW - 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    RMISS  = 3'd2,
    WTHRU  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [63:3]     addr_r;
  logic            wren_r;
  logic [63:0]     wdata_r;
  logic            hit_r;
  logic [63:0]     resp_data_r;
  logic [LINES-1:0] valid_r;

  logic [TAGW-1:0] tag_mem  [LINES];
  logic [63:0]     data_mem [LINES];

  logic            bus_req_r;
  logic            bus_we_r;
  logic [63:0]     bus_addr_r;
  logic [63:0]     bus_wdata_r;
  logic            done_r;
  logic [63:0]     rdata_r;

  logic [IDXW-1:0] idx_s;
  logic [TAGW-1:0] tag_s;
  logic            hit_s;
  logic            ack_s;

  assign idx_s = addr_r[IDXW+2:3];
  assign tag_s = addr_r[63:IDXW+3];
  assign hit_s = valid_r[idx_s] && (tag_mem[idx_s] == tag_s);
  // An acknowledge only counts while a request is actually outstanding.
  assign ack_s = cif.bus_ack & bus_req_r;

  assign cif.dcache_rdata = rdata_r;
  assign cif.dcache_done  = done_r;
  assign cif.bus_req      = bus_req_r;
  assign cif.bus_we       = bus_we_r;
  assign cif.bus_addr     = bus_addr_r;
  assign cif.bus_wdata    = bus_wdata_r;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cif.dcache_en) begin
          state_s = LOOKUP;
        end else begin
          state_s = IDLE;
        end
      end
      LOOKUP: begin
        if (wren_r) begin
          state_s = WTHRU;
        end else if (hit_s) begin
          state_s = RESP;
        end else begin
          state_s = RMISS;
        end
      end
      RMISS, WTHRU: begin
        if (ack_s) begin
          state_s = RESP;
        end else begin
          state_s = state_r;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request capture, bus drive, valid bits and registered responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r      <= {61{1'b0}};
      wren_r      <= 1'b0;
      wdata_r     <= 64'd0;
      hit_r       <= 1'b0;
      resp_data_r <= 64'd0;
      valid_r     <= {LINES{1'b0}};
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 64'd0;
      bus_wdata_r <= 64'd0;
      done_r      <= 1'b0;
      rdata_r     <= 64'd0;
    end else begin
      // The pulse trails the RESP state by one register stage; writes keep the old rdata.
      done_r <= (state_r == RESP);
      if ((state_r == RESP) && !wren_r) begin
        rdata_r <= resp_data_r;
      end
      case (state_r)
        IDLE: begin
          if (cif.dcache_en) begin
            addr_r  <= cif.dcache_addr[63:3];
            wren_r  <= cif.dcache_wren;
            wdata_r <= cif.dcache_wdata;
          end
        end
        LOOKUP: begin
          hit_r       <= hit_s;
          resp_data_r <= data_mem[idx_s];
          if (wren_r || !hit_s) begin
            bus_req_r   <= 1'b1;
            bus_we_r    <= wren_r;
            bus_addr_r  <= {addr_r, 3'b000};
            bus_wdata_r <= wdata_r;
          end
        end
        RMISS: begin
          if (ack_s) begin
            bus_req_r      <= 1'b0;
            bus_we_r       <= 1'b0;
            resp_data_r    <= cif.bus_rdata;
            valid_r[idx_s] <= 1'b1;
          end
        end
        WTHRU: begin
          if (ack_s) begin
            bus_req_r <= 1'b0;
            bus_we_r  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Line storage has no reset; valid_r alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if ((state_r == RMISS) && ack_s) begin
      tag_mem[idx_s]  <= tag_s;
      data_mem[idx_s] <= cif.bus_rdata;
    end else if ((state_r == WTHRU) && ack_s && hit_r) begin
      data_mem[idx_s] <= wdata_r;
    end
  end

endmodule
